// File: rtl/frame_pkg.sv
// Shared types and helpers for the analysis-frame address generator.
package frame_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when [base, base+size) lies inside [base, lim); one extra bit so a frame near the top never wraps.
  function automatic logic frame_fits(input addr_t base, input addr_t lim, input int unsigned size);
    return ({1'b0, base} + (ADDR_W + 1)'(size)) <= {1'b0, lim};
  endfunction

endpackage

// File: rtl/frame_gen.sv
// Walks [i_start_addr, i_end_addr) emitting one overlapping frame window per cycle, then pulses o_done.
// Handshake: o_valid is a one-cycle qualifier with no ready; the consumer must take every frame it flags.
module frame_gen
  import frame_pkg::*;
#(
  parameter int unsigned FRAME_SIZE    = 64,
  parameter int unsigned FRAME_OVERLAP = 32
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_start,
  input  addr_t  i_start_addr,
  input  addr_t  i_end_addr,
  output addr_t  o_frame_start,
  output addr_t  o_frame_end,
  output logic   o_done,
  output logic   o_valid,
  output state_t o_state
);

  localparam int unsigned HOP = FRAME_SIZE - FRAME_OVERLAP;
  localparam addr_t HOP_A = ADDR_W'(HOP);
  localparam addr_t FS_A  = ADDR_W'(FRAME_SIZE);

  state_t state_q, state_d;
  addr_t  cursor_q, cursor_d;
  addr_t  end_q, end_d;
  addr_t  fstart_q, fstart_d;
  addr_t  fend_q, fend_d;
  logic   valid_q, valid_d;
  logic   done_q, done_d;

  // In RUN the output registers already show a frame and cursor_q is the start of the next candidate.
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    end_d    = end_q;
    fstart_d = fstart_q;
    fend_d   = fend_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          end_d = i_end_addr;
          if (frame_fits(i_start_addr, i_end_addr, FRAME_SIZE)) begin
            state_d  = RUN;
            valid_d  = 1'b1;
            fstart_d = i_start_addr;
            fend_d   = i_start_addr + FS_A;
            cursor_d = i_start_addr + HOP_A;
          end else begin
            state_d  = DONE;
            done_d   = 1'b1;
            cursor_d = i_start_addr;
          end
        end
      end
      RUN: begin
        if (frame_fits(cursor_q, end_q, FRAME_SIZE)) begin
          valid_d  = 1'b1;
          fstart_d = cursor_q;
          fend_d   = cursor_q + FS_A;
          cursor_d = cursor_q + HOP_A;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cursor_q <= '0;
      end_q    <= '0;
      fstart_q <= '0;
      fend_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      end_q    <= end_d;
      fstart_q <= fstart_d;
      fend_q   <= fend_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign o_frame_start = fstart_q;
  assign o_frame_end   = fend_q;
  assign o_valid       = valid_q;
  assign o_done        = done_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_frame_gen.sv
// Directed bench for frame_gen: table of address ranges plus hand-written reset and restart sequences.
module tb_frame_gen;
  import frame_pkg::*;

  localparam int unsigned FS  = 64;
  localparam int unsigned HOP = 32;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   i_start = 1'b0;
  addr_t  i_start_addr = '0;
  addr_t  i_end_addr = '0;
  addr_t  o_frame_start, o_frame_end;
  logic   o_done, o_valid;
  state_t o_state;

  int n_checks = 0;
  int n_fail   = 0;

  frame_gen #(.FRAME_SIZE(64), .FRAME_OVERLAP(32)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_start_addr(i_start_addr), .i_end_addr(i_end_addr),
    .o_frame_start(o_frame_start), .o_frame_end(o_frame_end),
    .o_done(o_done), .o_valid(o_valid), .o_state(o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    addr_t s;
    addr_t e;
    int    n;
    addr_t last;
    string name;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse i_start for one accepting edge, then scramble the address inputs.
  task automatic start_run(input addr_t s, input addr_t e);
    @(negedge clk);
    i_start      = 1'b1;
    i_start_addr = s;
    i_end_addr   = e;
    tick();
    i_start      = 1'b0;
    i_start_addr = 32'hDEAD_0000;
    i_end_addr   = 32'hFFFF_FFFF;
  endtask

  // Called #1 after the accepting edge; follows the run until o_done.
  task automatic check_run(input string name, input addr_t s, input int exp_n,
                           input addr_t exp_last, input int poke);
    addr_t exp_q[$];
    addr_t e_start;
    addr_t last_start = '0;
    int    got = 0;
    bit    done_seen = 1'b0;
    for (int k = 0; k < exp_n; k++) exp_q.push_back(s + ADDR_W'(k * HOP));
    chk({name, "_first_valid"}, 64'(o_valid), 64'(exp_n > 0));
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      if (cyc == poke) begin
        i_start      = 1'b1;
        i_start_addr = 32'h0;
        i_end_addr   = 32'h0001_0000;
      end else if (cyc == poke + 1) begin
        i_start = 1'b0;
      end
      chk({name, "_valid_done_excl"}, 64'(o_valid & o_done), 64'd0);
      if (o_valid) begin
        chk({name, "_no_extra_frame"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e_start = exp_q.pop_front();
          chk({name, "_frame_start"}, 64'(o_frame_start), 64'(e_start));
          chk({name, "_frame_end"}, 64'(o_frame_end), 64'(e_start + ADDR_W'(FS)));
          last_start = o_frame_start;
          got++;
        end
      end
      if (o_done) done_seen = 1'b1;
      else tick();
    end
    i_start = 1'b0;
    chk({name, "_done_seen"}, 64'(done_seen), 64'd1);
    chk({name, "_frame_count"}, 64'(got), 64'(exp_n));
    if (exp_n > 0) chk({name, "_last_start"}, 64'(last_start), 64'(exp_last));
    tick();
    chk({name, "_done_one_cycle"}, 64'(o_done), 64'd0);
    chk({name, "_idle_valid"}, 64'(o_valid), 64'd0);
    chk({name, "_idle_state"}, 64'(o_state), 64'(IDLE));
    if (exp_n > 0) begin
      chk({name, "_hold_start"}, 64'(o_frame_start), 64'(exp_last));
      chk({name, "_hold_end"}, 64'(o_frame_end), 64'(exp_last + ADDR_W'(FS)));
    end
  endtask

  initial begin
    vecs[0] = '{32'h8000_0000, 32'h8000_0100, 7,  32'h8000_00C0, "basic"};
    vecs[1] = '{32'h1000_0000, 32'h1000_0C00, 95, 32'h1000_0BC0, "long"};
    vecs[2] = '{32'h0000_1000, 32'h0000_103F, 0,  32'h0,         "short"};
    vecs[3] = '{32'h0000_1000, 32'h0000_1000, 0,  32'h0,         "empty"};
    vecs[4] = '{32'h0000_2000, 32'h0000_1000, 0,  32'h0,         "reversed"};
    vecs[5] = '{32'h0000_0000, 32'h0000_0070, 2,  32'h0000_0020, "partial"};
    vecs[6] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 6,  32'hFFFF_FFA0, "near_ovf"};
    vecs[7] = '{32'h0000_0100, 32'h0000_0140, 1,  32'h0000_0100, "exact"};
    vecs[8] = '{32'h0000_0000, 32'h0000_0060, 2,  32'h0000_0020, "two_exact"};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_fstart", 64'(o_frame_start), 64'd0);
    chk("rst_fend", 64'(o_frame_end), 64'd0);
    chk("rst_state", 64'(o_state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick();

    foreach (vecs[i]) begin
      start_run(vecs[i].s, vecs[i].e);
      check_run(vecs[i].name, vecs[i].s, vecs[i].n, vecs[i].last, -10);
      repeat (2) tick();
    end

    // A start request in the middle of a run must not disturb it
    start_run(32'h8000_0000, 32'h8000_0100);
    check_run("poke_run", 32'h8000_0000, 7, 32'h8000_00C0, 2);
    repeat (3) tick();
    chk("poke_not_queued_valid", 64'(o_valid), 64'd0);
    chk("poke_not_queued_state", 64'(o_state), 64'(IDLE));

    // Reset mid-run aborts at once and never produces o_done
    start_run(32'h8000_0000, 32'h8000_0100);
    repeat (2) tick();
    chk("abort_pre_valid", 64'(o_valid), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid", 64'(o_valid), 64'd0);
    chk("abort_fstart", 64'(o_frame_start), 64'd0);
    chk("abort_fend", 64'(o_frame_end), 64'd0);
    chk("abort_state", 64'(o_state), 64'(IDLE));
    chk("abort_done", 64'(o_done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_done", 64'(o_done), 64'd0);
      chk("abort_no_valid", 64'(o_valid), 64'd0);
    end
    start_run(32'h8000_0000, 32'h8000_0100);
    check_run("after_abort", 32'h8000_0000, 7, 32'h8000_00C0, -10);

    // i_start held through DONE restarts on the first IDLE edge
    @(negedge clk);
    i_start      = 1'b1;
    i_start_addr = 32'h0000_0500;
    i_end_addr   = 32'h0000_0500;
    tick();
    chk("held_done1", 64'(o_done), 64'd1);
    chk("held_state_done", 64'(o_state), 64'(DONE));
    i_start_addr = 32'h0000_0000;
    i_end_addr   = 32'h0000_0040;
    tick();
    chk("held_done_drop", 64'(o_done), 64'd0);
    chk("held_state_idle", 64'(o_state), 64'(IDLE));
    tick();
    i_start = 1'b0;
    check_run("held_restart", 32'h0000_0000, 1, 32'h0000_0000, -10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/frame_gen.md
Name: frame_gen

Overview:
- Address-range framer for the speech front end.
- Given a sample buffer [i_start_addr, i_end_addr), it emits one overlapping analysis-frame address window per clock: frame start and exclusive frame end.
- It then pulses done when the range is exhausted.
- Downstream windowing/FFT stages consume the windows to fetch samples.

Parameters:
- FRAME_SIZE, 64, frame length in address units; must be >0.
- FRAME_OVERLAP, 32, overlap between consecutive frames in address units; must be < FRAME_SIZE. Hop HOP = FRAME_SIZE - FRAME_OVERLAP, a localparam.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_start_addr  in  32  first address of buffer; latched on accepted start.
- i_end_addr  in  32  one past last address of buffer (exclusive); latched on accepted start.
- o_frame_start  out  32  first address of current frame.
- o_frame_end  out  32  one past last address of current frame, = o_frame_start + FRAME_SIZE.
- o_done  out  1  one-cycle pulse: range finished.
- o_valid  out  1  o_frame_start/o_frame_end hold a new frame this cycle.

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, internal registers 0.
- States: IDLE, RUN, DONE.
- IDLE: on a rising edge with i_start=1, latch both addresses and set the cursor to i_start_addr.
  - If start+FRAME_SIZE <= end (evaluated in 33-bit unsigned arithmetic, no wrap), go to RUN.
  - Otherwise go straight to DONE; zero frames are emitted.
- RUN, each cycle:
  - Register o_valid=1, o_frame_start=cursor, o_frame_end=cursor+FRAME_SIZE.
  - Advance cursor += HOP.
  - If the next frame (cursor+HOP+FRAME_SIZE) > end (33-bit compare), go to DONE after this frame.
- DONE: o_valid=0, o_done=1 for exactly one cycle, then return to IDLE.
- Latency: first o_valid is the cycle immediately after the edge that accepted i_start. Frames are then back-to-back, one per cycle, no gaps.
- o_done asserts the cycle after the last valid frame. o_valid and o_done are never high together.
- Frame count N = floor((end-start-FRAME_SIZE)/HOP)+1 when end-start >= FRAME_SIZE, else 0.
  - A trailing partial frame is dropped, never padded.
- o_frame_start/o_frame_end hold the last emitted values while o_valid=0. They are cleared only by reset.
- i_start in RUN or DONE is ignored, not queued. Input address changes after acceptance have no effect.
- i_start held high across DONE→IDLE starts a new run on the first IDLE edge.
- end <= start: treated as empty → DONE pulse only.
- Reset mid-run aborts immediately: outputs 0, IDLE, no o_done.
- No backpressure: the consumer must accept one frame per cycle.

Decomposition:
- Package frame_pkg holds:
  - ADDR_W=32.
  - State enum typedef (IDLE, RUN, DONE).
  - Address typedef logic [ADDR_W-1:0].
- No sub-module needed: single FSM plus a cursor/adder datapath in one module.

Test Plan:
- Basic run, FRAME_SIZE=64, FRAME_OVERLAP=32: start=0x80000000, end=0x80000100, 1-cycle i_start → 7 consecutive valid frames, starts 0x80000000…0x800000C0 step 0x20, ends = start+0x40. o_done pulses the cycle after the 0x800000C0 frame.
- Second run, 200 ns later, no reset: start=0x10000000, end=0x10000C00 → 95 frames, last start 0x10000BC0 / end 0x10000C00, then one o_done pulse.
- Short/empty range: end=start+0x3F, and end=start → zero o_valid, single o_done the cycle after start.
- Partial tail: start=0, end=0x70 → frames 0x00 and 0x20 only (0x40 frame would end at 0x80 > 0x70), then done.
- Start during RUN ignored; reset asserted mid-run → outputs 0 immediately, no o_done; a fresh start afterwards behaves as in the basic-run case.
- Near-overflow: start=0xFFFFFF00, end=0xFFFFFFFF → 6 frames (starts …00 to …A0), no wraparound frames emitted.
